// File: rtl/issue_ctrl_if.sv
// Issue-stage bus: fetch handshake in, decoder view out,
// backend back-pressure in, issue pulses out.
interface issue_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              rdy;
  logic              flush;
  logic              if_valid;
  logic [31:0]       if_inst;
  logic [31:0]       if_pc;
  logic              if_ready;
  logic [31:0]       dec_inst;
  logic [31:0]       dec_pc;
  logic              rob_full;
  logic              rs_full;
  logic              lsb_full;
  logic              issue_rob;
  logic              issue_rs;
  logic              issue_lsb;
  logic              issue_drop;
  logic [31:0]       issue_inst;
  logic [31:0]       issue_pc;
  logic [ADDR_W:0]   count;

  modport master (
    output rdy, flush,
    output if_valid, if_inst, if_pc,
    output rob_full, rs_full, lsb_full,
    input  if_ready, dec_inst, dec_pc,
    input  issue_rob, issue_rs,
    input  issue_lsb, issue_drop,
    input  issue_inst, issue_pc, count
  );

  modport slave (
    input  rdy, flush,
    input  if_valid, if_inst, if_pc,
    input  rob_full, rs_full, lsb_full,
    output if_ready, dec_inst, dec_pc,
    output issue_rob, issue_rs,
    output issue_lsb, issue_drop,
    output issue_inst, issue_pc, count
  );
endinterface

// File: rtl/issue_ctrl.sv
// Issue sequencer: instruction FIFO feeding ROB plus RS/LSB,
// one dispatch per cycle, flushed on mispredict.
module issue_ctrl #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic         clk,
  input logic         rst,
  issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ISSUE,
    S_STALL,
    S_FLUSH
  } state_t;

  typedef enum logic [1:0] {
    R_DROP,
    R_RS,
    R_LSB
  } route_t;

  localparam logic [ADDR_W:0] FULL =
    (ADDR_W+1)'(DEPTH);

  logic [31:0]       inst_q [DEPTH];
  logic [31:0]       pc_q   [DEPTH];
  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_n;
  state_t            state;
  state_t            state_n;

  logic        rob_q;
  logic        rs_q;
  logic        lsb_q;
  logic        drop_q;
  logic [31:0] iinst_q;
  logic [31:0] ipc_q;

  logic        has_head;
  logic [6:0]  op;
  logic        is_ls;
  logic        is_alu;
  route_t      route;
  logic        res_ok;
  logic        live;
  logic        enq;
  logic        pop;
  logic        stall;

  assign has_head = (cnt != '0);

  assign bus.if_ready =
    (cnt != FULL) && (state != S_FLUSH);

  assign bus.dec_inst =
    has_head ? inst_q[head] : '0;
  assign bus.dec_pc =
    has_head ? pc_q[head] : '0;

  assign op = bus.dec_inst[6:0];

  assign is_ls =
    (op == 7'b0000011) || (op == 7'b0100011);

  assign is_alu = op inside {
    7'b0110111, 7'b0010111, 7'b1101111,
    7'b1100111, 7'b1100011, 7'b0010011,
    7'b0110011
  };

  always_comb begin
    route = R_DROP;
    unique case (1'b1)
      is_ls:   route = R_LSB;
      is_alu:  route = R_RS;
      default: route = R_DROP;
    endcase
  end

  always_comb begin
    res_ok = 1'b1;
    unique case (route)
      R_LSB:
        res_ok = !bus.rob_full && !bus.lsb_full;
      R_RS:
        res_ok = !bus.rob_full && !bus.rs_full;
      default:
        res_ok = 1'b1;
    endcase
  end

  // Frozen, flushing or recovering cycles neither fill nor drain.
  assign live = bus.rdy && !bus.flush &&
                (state != S_FLUSH);
  assign enq   = live && bus.if_valid && bus.if_ready;
  assign pop   = live && has_head && res_ok;
  assign stall = live && has_head && !res_ok;

  assign cnt_n = cnt
               + (ADDR_W+1)'(enq)
               - (ADDR_W+1)'(pop);

  always_comb begin
    state_n = S_ISSUE;
    if (state == S_FLUSH)
      state_n = S_EMPTY;
    else if (cnt_n == '0)
      state_n = S_EMPTY;
    else if (stall)
      state_n = S_STALL;
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      inst_q[tail] <= bus.if_inst;
      pc_q[tail]   <= bus.if_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      state   <= S_EMPTY;
      rob_q   <= 1'b0;
      rs_q    <= 1'b0;
      lsb_q   <= 1'b0;
      drop_q  <= 1'b0;
      iinst_q <= '0;
      ipc_q   <= '0;
    end else if (!bus.rdy) begin
      rob_q  <= 1'b0;
      rs_q   <= 1'b0;
      lsb_q  <= 1'b0;
      drop_q <= 1'b0;
    end else if (bus.flush) begin
      head   <= '0;
      tail   <= '0;
      cnt    <= '0;
      state  <= S_FLUSH;
      rob_q  <= 1'b0;
      rs_q   <= 1'b0;
      lsb_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      rob_q  <= pop && (route != R_DROP);
      rs_q   <= pop && (route == R_RS);
      lsb_q  <= pop && (route == R_LSB);
      drop_q <= pop && (route == R_DROP);
      if (pop) begin
        iinst_q <= bus.dec_inst;
        ipc_q   <= bus.dec_pc;
        head    <= head + 1'b1;
      end
      if (enq)
        tail <= tail + 1'b1;
      cnt   <= cnt_n;
      state <= state_n;
    end
  end

  // A pulse latched before a freeze must not leak into it.
  assign bus.issue_rob  = rob_q  && bus.rdy;
  assign bus.issue_rs   = rs_q   && bus.rdy;
  assign bus.issue_lsb  = lsb_q  && bus.rdy;
  assign bus.issue_drop = drop_q && bus.rdy;
  assign bus.issue_inst = iinst_q;
  assign bus.issue_pc   = ipc_q;
  assign bus.count      = cnt;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: latency, stall, fill/wrap,
// flush, drop, freeze and async reset.
module tb_issue_ctrl;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  issue_ctrl_if #(.ADDR_W(4)) bus ();

  issue_ctrl #(
    .DEPTH (16),
    .ADDR_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pulses();
    return {28'b0, bus.issue_rob, bus.issue_rs,
            bus.issue_lsb, bus.issue_drop};
  endfunction

  task automatic push(
    input logic [31:0] inst,
    input logic [31:0] pc
  );
    bus.if_valid = 1'b1;
    bus.if_inst  = inst;
    bus.if_pc    = pc;
    step();
    bus.if_valid = 1'b0;
  endtask

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] SW   = 32'h00112023;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    bus.rdy      = 1'b1;
    bus.flush    = 1'b0;
    bus.if_valid = 1'b0;
    bus.if_inst  = '0;
    bus.if_pc    = '0;
    bus.rob_full = 1'b0;
    bus.rs_full  = 1'b0;
    bus.lsb_full = 1'b0;
    step();
    step();
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_ready", 32'(bus.if_ready), 1);
    chk("rst_pulse", pulses(), 0);
    chk("rst_dec", bus.dec_inst, 0);
    chk("rst_ipc", bus.issue_pc, 0);
    chk("rst_iinst", bus.issue_inst, 0);
    rst = 1'b0;

    // addi: head after 1 edge, pulse after 2
    push(ADDI, 32'h0);
    chk("t1_count", 32'(bus.count), 1);
    chk("t1_dec", bus.dec_inst, ADDI);
    chk("t1_early", pulses(), 0);
    step();
    chk("t1_pulse", pulses(), 32'b1100);
    chk("t1_pc", bus.issue_pc, 0);
    chk("t1_inst", bus.issue_inst, ADDI);
    chk("t1_count0", 32'(bus.count), 0);
    step();
    chk("t1_clear", pulses(), 0);

    // sw stalled on full LSB
    bus.lsb_full = 1'b1;
    push(SW, 32'h4);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_stall", pulses(), 0);
      chk("t2_hold", bus.dec_inst, SW);
      chk("t2_count", 32'(bus.count), 1);
    end
    bus.lsb_full = 1'b0;
    step();
    chk("t2_pulse", pulses(), 32'b1010);
    chk("t2_pc", bus.issue_pc, 32'h4);
    step();
    chk("t2_clear", pulses(), 0);

    // fill 16 behind a full ROB, 17th refused
    bus.rob_full = 1'b1;
    for (int i = 0; i < 17; i++)
      push(32'h00000013 | (32'(i) << 20),
           32'h100 + 32'(i) * 4);
    chk("t3_count", 32'(bus.count), 16);
    chk("t3_ready", 32'(bus.if_ready), 0);
    chk("t3_head", bus.dec_pc, 32'h100);
    chk("t3_none", pulses(), 0);
    bus.rob_full = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("t3_pulse", pulses(), 32'b1100);
      chk("t3_pc", bus.issue_pc,
          32'h100 + 32'(i) * 4);
    end
    chk("t3_empty", 32'(bus.count), 0);
    step();
    chk("t3_clear", pulses(), 0);
    chk("t3_ready1", 32'(bus.if_ready), 1);

    // flush with 5 queued and fetch still pushing
    bus.rob_full = 1'b1;
    for (int i = 0; i < 5; i++)
      push(ADDI, 32'h200 + 32'(i) * 4);
    chk("t4_count5", 32'(bus.count), 5);
    bus.flush    = 1'b1;
    bus.if_valid = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("t4_count0", 32'(bus.count), 0);
    chk("t4_ready0", 32'(bus.if_ready), 0);
    chk("t4_nop1", pulses(), 0);
    step();
    chk("t4_noenq", 32'(bus.count), 0);
    chk("t4_nop2", pulses(), 0);
    chk("t4_ready1", 32'(bus.if_ready), 1);
    bus.if_valid = 1'b0;
    bus.rob_full = 1'b0;
    step();
    chk("t4_idle", pulses(), 0);
    chk("t4_dec", bus.dec_inst, 0);

    // unknown opcode dropped, next one issues
    push(32'h0, 32'h300);
    push(ADDI, 32'h304);
    chk("t5_drop", pulses(), 32'b0001);
    chk("t5_count", 32'(bus.count), 1);
    chk("t5_head", bus.dec_pc, 32'h304);
    step();
    chk("t5_pulse", pulses(), 32'b1100);
    chk("t5_pc", bus.issue_pc, 32'h304);

    // freeze: flush and fetch must be ignored
    bus.rob_full = 1'b1;
    push(ADDI, 32'h400);
    push(SW, 32'h404);
    chk("t6_count", 32'(bus.count), 2);
    bus.rdy      = 1'b0;
    bus.rob_full = 1'b0;
    bus.flush    = 1'b1;
    bus.if_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_frz_cnt", 32'(bus.count), 2);
      chk("t6_frz_pls", pulses(), 0);
      chk("t6_frz_pc", bus.dec_pc, 32'h400);
    end
    bus.rdy      = 1'b1;
    bus.flush    = 1'b0;
    bus.if_valid = 1'b0;
    step();
    chk("t6_iss1", pulses(), 32'b1100);
    chk("t6_pc1", bus.issue_pc, 32'h400);
    step();
    chk("t6_iss2", pulses(), 32'b1010);
    chk("t6_pc2", bus.issue_pc, 32'h404);
    step();
    chk("t6_done", 32'(bus.count), 0);

    // asynchronous reset mid-operation
    bus.rob_full = 1'b1;
    for (int i = 0; i < 3; i++)
      push(ADDI, 32'h500 + 32'(i) * 4);
    chk("t7_count3", 32'(bus.count), 3);
    #2 rst = 1'b1;
    #1;
    chk("t7_count", 32'(bus.count), 0);
    chk("t7_ready", 32'(bus.if_ready), 1);
    chk("t7_dec", bus.dec_inst, 0);
    chk("t7_pulse", pulses(), 0);
    step();
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
